ddr3_avl_arbiter: RTL and testbench

//   Shares the single DDR3 controller Avalon port between two masters: m0 (display/VGA frame fetch)
//   and m1 (CSR/image loader). Arbitrates commands, locks the port for whole write bursts, and returns

---
 rtl/ddr3_avl_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ddr3_avl_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_avl_arbiter.sv
// Two-master arbiter for the DDR3 controller Avalon port, with write-burst locking and in-order read return.
// Define DDR3_ARB_FIXED_PRIO_EN for fixed priority (m0 always wins) instead of round-robin.
module ddr3_avl_arbiter #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 128,
  parameter int SIZE_W    = 3,
  parameter int TAG_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_read_req,
  input  logic              m0_write_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SIZE_W-1:0] m0_size,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_read_data,
  output logic              m0_read_valid,
  input  logic              m1_read_req,
  input  logic              m1_write_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SIZE_W-1:0] m1_size,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_read_data,
  output logic              m1_read_valid,
  input  logic              avl_ready,
  output logic              avl_burstbegin,
  output logic [ADDR_W-1:0] avl_addr,
  output logic [SIZE_W-1:0] avl_size,
  output logic [DATA_W-1:0] avl_wr_data,
  output logic              avl_read_req,
  output logic              avl_write_req,
  input  logic [DATA_W-1:0] avl_read_data,
  input  logic              avl_read_valid,
  output logic              err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic {IDLE, WR_BURST} state_t;

  state_t            state_q, state_d;
  logic              lock_q, lock_d;
  logic [SIZE_W-1:0] wr_left_q, wr_left_d;
  logic [PTR_W:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [SIZE_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              err_orphan_q, err_orphan_d;
  logic              tag_id_q   [TAG_DEPTH];
  logic [SIZE_W-1:0] tag_size_q [TAG_DEPTH];

  logic              fifo_empty, fifo_full, elig0, elig1, rr_pick;
  logic              gnt_vld, gnt_id, gnt_rd, burst_first, cmd_done;
  logic              push, pop, beat_ok, head_id;
  logic [SIZE_W-1:0] gnt_size_eff, head_size;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);

  // A pending read takes precedence inside a master, so a full tag FIFO also holds back its write.
  assign elig0 = m0_read_req ? ~fifo_full : m0_write_req;
  assign elig1 = m1_read_req ? ~fifo_full : m1_write_req;

`ifdef DDR3_ARB_FIXED_PRIO_EN
  assign rr_pick = ~elig0;
`else
  logic last_grant_q, last_grant_d;
  assign rr_pick = (elig0 & elig1) ? ~last_grant_q : elig1;
`endif

  always_comb begin
    gnt_vld     = 1'b0;
    gnt_id      = 1'b0;
    gnt_rd      = 1'b0;
    burst_first = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_id      = rr_pick;
        gnt_vld     = elig0 | elig1;
        gnt_rd      = rr_pick ? m1_read_req : m0_read_req;
        burst_first = 1'b1;
      end
      WR_BURST: begin
        gnt_id  = lock_q;
        gnt_vld = lock_q ? m1_write_req : m0_write_req;
      end
      default: ;
    endcase
    if (reset) gnt_vld = 1'b0;
  end

  assign cmd_done       = gnt_vld & avl_ready;
  assign avl_read_req   = gnt_vld & gnt_rd;
  assign avl_write_req  = gnt_vld & ~gnt_rd;
  assign avl_burstbegin = gnt_vld & burst_first;
  assign avl_addr       = gnt_id ? m1_addr    : m0_addr;
  assign avl_size       = gnt_id ? m1_size    : m0_size;
  assign avl_wr_data    = gnt_id ? m1_wr_data : m0_wr_data;
  assign m0_ready       = cmd_done & ~gnt_id;
  assign m1_ready       = cmd_done & gnt_id;
  assign gnt_size_eff   = (avl_size == '0) ? SIZE_W'(1) : avl_size;

  assign push      = cmd_done & gnt_rd;
  assign head_id   = tag_id_q[rptr_q[PTR_W-1:0]];
  assign head_size = tag_size_q[rptr_q[PTR_W-1:0]];
  assign beat_ok   = avl_read_valid & ~fifo_empty & ~reset;
  assign pop       = beat_ok & (rd_cnt_q == head_size - SIZE_W'(1));

  assign m0_read_data  = avl_read_data;
  assign m1_read_data  = avl_read_data;
  assign m0_read_valid = beat_ok & ~head_id;
  assign m1_read_valid = beat_ok & head_id;
  assign err_orphan    = err_orphan_q;

  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    wr_left_d    = wr_left_q;
    rd_cnt_d     = rd_cnt_q;
    err_orphan_d = err_orphan_q;
`ifndef DDR3_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    if (cmd_done) begin
      if (state_q == IDLE) begin
`ifndef DDR3_ARB_FIXED_PRIO_EN
        last_grant_d = gnt_id;
`endif
        if (~gnt_rd && (gnt_size_eff > SIZE_W'(1))) begin
          state_d   = WR_BURST;
          lock_d    = gnt_id;
          wr_left_d = gnt_size_eff - SIZE_W'(1);
        end
      end else begin
        wr_left_d = wr_left_q - SIZE_W'(1);
        if (wr_left_q == SIZE_W'(1)) state_d = IDLE;
      end
    end
    wptr_d = wptr_q + {{PTR_W{1'b0}}, push};
    rptr_d = rptr_q + {{PTR_W{1'b0}}, pop};
    if (beat_ok) rd_cnt_d = pop ? '0 : rd_cnt_q + SIZE_W'(1);
    if (avl_read_valid & fifo_empty) err_orphan_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lock_q       <= 1'b0;
      wr_left_q    <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      rd_cnt_q     <= '0;
      err_orphan_q <= 1'b0;
`ifndef DDR3_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      wr_left_q    <= wr_left_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      rd_cnt_q     <= rd_cnt_d;
      err_orphan_q <= err_orphan_d;
`ifndef DDR3_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Tag payload is only meaningful between the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_id_q[wptr_q[PTR_W-1:0]]   <= gnt_id;
      tag_size_q[wptr_q[PTR_W-1:0]] <= gnt_size_eff;
    end
  end

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Randomized and directed checks of ddr3_avl_arbiter against a queue-based reference model.
module tb_ddr3_avl_arbiter;
  localparam int ADDR_W = 26, DATA_W = 128, SIZE_W = 3, TAG_DEPTH = 8;

  logic clk = 1'b0, reset;
  logic m0_read_req, m0_write_req, m1_read_req, m1_write_req;
  logic [ADDR_W-1:0] m0_addr, m1_addr, avl_addr;
  logic [SIZE_W-1:0] m0_size, m1_size, avl_size;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data, m0_read_data, m1_read_data, avl_wr_data, avl_read_data;
  logic m0_ready, m1_ready, m0_read_valid, m1_read_valid;
  logic avl_ready, avl_burstbegin, avl_read_req, avl_write_req, avl_read_valid, err_orphan;

  ddr3_avl_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .m0_read_req(m0_read_req), .m0_write_req(m0_write_req), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_wr_data(m0_wr_data), .m0_ready(m0_ready), .m0_read_data(m0_read_data), .m0_read_valid(m0_read_valid),
    .m1_read_req(m1_read_req), .m1_write_req(m1_write_req), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_wr_data(m1_wr_data), .m1_ready(m1_ready), .m1_read_data(m1_read_data), .m1_read_valid(m1_read_valid),
    .avl_ready(avl_ready), .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr), .avl_size(avl_size),
    .avl_wr_data(avl_wr_data), .avl_read_req(avl_read_req), .avl_write_req(avl_write_req),
    .avl_read_data(avl_read_data), .avl_read_valid(avl_read_valid), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: outstanding reads as a queue of (master, beats), plus burst lock bookkeeping.
  int   mq_id[$], mq_sz[$];
  int   m_rdcnt = 0, m_lock = -1, m_left = 0, m_last = 1, m_pend = 0;
  logic m_err = 1'b0;
  logic w0, w1, e_rd, e_wr, e_bb, e_v0, e_v1, e_done;
  int   e_id, e_sz;

  function automatic int eff(input logic [SIZE_W-1:0] s);
    return (s == 0) ? 1 : int'(s);
  endfunction

  always @(negedge clk) begin
    e_rd = 0; e_wr = 0; e_bb = 0; e_v0 = 0; e_v1 = 0; e_id = 0;
    if (reset) begin
      chk("reset_outputs", {avl_read_req, avl_write_req, avl_burstbegin, m0_ready, m1_ready,
                            m0_read_valid, m1_read_valid, err_orphan}, 8'h00);
      mq_id.delete(); mq_sz.delete();
      m_rdcnt = 0; m_lock = -1; m_left = 0; m_last = 1; m_pend = 0; m_err = 0;
    end else begin
      if (m_lock >= 0) begin
        e_id = m_lock;
        e_wr = (m_lock == 1) ? m1_write_req : m0_write_req;
      end else begin
        w0 = m0_read_req ? (mq_id.size() < TAG_DEPTH) : m0_write_req;
        w1 = m1_read_req ? (mq_id.size() < TAG_DEPTH) : m1_write_req;
        if (w0 || w1) begin
`ifdef DDR3_ARB_FIXED_PRIO_EN
          e_id = w0 ? 0 : 1;
`else
          if (w0 && w1) e_id = (m_last == 0) ? 1 : 0;
          else          e_id = w0 ? 0 : 1;
`endif
          e_rd = (e_id == 1) ? m1_read_req : m0_read_req;
          e_wr = !e_rd;
          e_bb = 1;
        end
      end
      e_done = (e_rd || e_wr) && avl_ready;
      if (avl_read_valid && mq_id.size() > 0) begin
        if (mq_id[0] == 0) e_v0 = 1; else e_v1 = 1;
      end
      chk("ctrl", {avl_read_req, avl_write_req, avl_burstbegin, m0_ready, m1_ready,
                   m0_read_valid, m1_read_valid, err_orphan},
                  {e_rd, e_wr, e_bb, e_done && e_id == 0, e_done && e_id == 1, e_v0, e_v1, m_err});
      if (e_rd || e_wr)
        chk("cmd_addr_size", {avl_addr, avl_size}, (e_id == 1) ? {m1_addr, m1_size} : {m0_addr, m0_size});
      if (e_wr)
        chk("wr_data", avl_wr_data, (e_id == 1) ? m1_wr_data : m0_wr_data);
      if (e_v0) chk("rd_data0", m0_read_data, avl_read_data);
      if (e_v1) chk("rd_data1", m1_read_data, avl_read_data);
      // Return path sees the queue as it was before this cycle's push.
      if (avl_read_valid) begin
        if (mq_id.size() == 0) m_err = 1;
        else begin
          m_rdcnt++;
          if (m_rdcnt == mq_sz[0]) begin
            void'(mq_id.pop_front()); void'(mq_sz.pop_front());
            m_rdcnt = 0;
          end
        end
      end
      if (e_done) begin
        e_sz = eff((e_id == 1) ? m1_size : m0_size);
        if (m_lock >= 0) begin
          m_left--;
          if (m_left == 0) m_lock = -1;
        end else begin
          m_last = e_id;
          if (e_rd) begin mq_id.push_back(e_id); mq_sz.push_back(e_sz); end
          else if (e_sz > 1) begin m_lock = e_id; m_left = e_sz - 1; end
        end
      end
      m_pend = -m_rdcnt;
      foreach (mq_sz[i]) m_pend += mq_sz[i];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while (m_pend > 0 && k < 300) begin
      avl_read_valid = 1'b1;
      avl_read_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      k++;
    end
    avl_read_valid = 1'b0;
    chk({nm, "_drain_timeout"}, 128'(m_pend != 0), 128'(0));
  endtask

  task automatic idle_inputs();
    m0_read_req = 0; m0_write_req = 0; m1_read_req = 0; m1_write_req = 0;
    m0_addr = '0; m1_addr = '0; m0_size = '0; m1_size = '0; m0_wr_data = '0; m1_wr_data = '0;
    avl_read_valid = 0; avl_read_data = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  int op;
  initial begin
    reset = 1; idle_inputs(); avl_ready = 1;
    m0_read_req = 1; m0_addr = 26'h55; m0_size = 3'd2;
    @(negedge clk);
    chk("rst_hold", {avl_read_req, avl_burstbegin, m0_ready, err_orphan}, 4'b0000);
    tick();
    reset = 0; m0_read_req = 0;

    // m0 read of 4 beats, returned to m0 only
    m0_read_req = 1; m0_addr = 26'h100; m0_size = 3'd4;
    @(negedge clk);
    chk("t1_cmd", {avl_read_req, avl_burstbegin, m0_ready, m1_ready}, 4'b1110);
    chk("t1_addr", avl_addr, 128'h100);
    tick(); m0_read_req = 0;
    for (int i = 0; i < 4; i++) begin
      avl_read_valid = 1; avl_read_data = {4{$urandom}};
      @(negedge clk);
      chk("t1_route", {m0_read_valid, m1_read_valid}, 2'b10);
      tick();
    end
    avl_read_valid = 0;
    @(negedge clk);
    chk("t1_model_empty", 128'(mq_id.size()), 128'(0));
    chk("t1_no_orphan", err_orphan, 0);
    tick();

    // both masters read every cycle
    m0_read_req = 1; m1_read_req = 1; m0_size = 1; m1_size = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef DDR3_ARB_FIXED_PRIO_EN
      chk("t2_grant", {m0_ready, m1_ready}, 2'b10);
`else
      chk("t2_grant", {m0_ready, m1_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
`endif
      tick();
    end
    m0_read_req = 0; m1_read_req = 0;
    avl_read_valid = 1;
    @(negedge clk);
`ifdef DDR3_ARB_FIXED_PRIO_EN
    chk("t2_route_first", {m0_read_valid, m1_read_valid}, 2'b10);
`else
    chk("t2_route_first", {m0_read_valid, m1_read_valid}, 2'b01);
`endif
    tick();
    drain("t2");

    // m1 write burst of 5 with m0 read arriving on beat 2
    m1_write_req = 1; m1_size = 5; m1_addr = 26'h300; m1_wr_data = {4{$urandom}};
    @(negedge clk);
    chk("t3_first", {avl_write_req, avl_burstbegin, m0_ready, m1_ready}, 4'b1101);
    tick();
    m0_read_req = 1; m0_addr = 26'h200; m0_size = 1;
    for (int b = 2; b <= 5; b++) begin
      m1_wr_data = {4{$urandom}};
      @(negedge clk);
      chk("t3_beat", {avl_write_req, avl_burstbegin, m0_ready, m1_ready}, 4'b1001);
      tick();
    end
    m1_write_req = 0;
    @(negedge clk);
    chk("t3_m0_after", {avl_read_req, avl_burstbegin, m0_ready, m1_ready}, 4'b1110);
    tick(); m0_read_req = 0;
    drain("t3");

    // controller stalls for 3 cycles mid write burst
    m0_write_req = 1; m0_size = 4; m0_addr = 26'h40;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("t4_pre", {avl_write_req, avl_burstbegin, m0_ready}, (b == 0) ? 3'b111 : 3'b101);
      tick();
    end
    avl_ready = 0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk("t4_stall", {avl_write_req, avl_burstbegin, m0_ready}, 3'b100);
      tick();
    end
    avl_ready = 1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("t4_post", {avl_write_req, avl_burstbegin, m0_ready}, 3'b101);
      tick();
    end
    m0_write_req = 0;
    @(negedge clk);
    chk("t4_done", avl_write_req, 0);
    tick();

    // tag FIFO full: 9th read held until the first burst has fully returned
    m0_read_req = 1; m0_size = 2;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); chk("t5_accept", m0_ready, 1); tick();
    end
    @(negedge clk); chk("t5_blocked", m0_ready, 0); tick();
    avl_read_valid = 1;
    @(negedge clk); chk("t5_beat1_blocked", m0_ready, 0); tick();
    @(negedge clk); chk("t5_pop_cycle_blocked", m0_ready, 0); tick();
    avl_read_valid = 0;
    @(negedge clk); chk("t5_unblocked", m0_ready, 1); tick();
    m0_read_req = 0;
    drain("t5");

    // orphan beat
    avl_read_valid = 1;
    @(negedge clk); chk("t6_err_before", err_orphan, 0); tick();
    avl_read_valid = 0;
    @(negedge clk); chk("t6_err_set", err_orphan, 1); tick();
    repeat (3) tick();
    @(negedge clk); chk("t6_err_sticky", err_orphan, 1); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      op = $urandom_range(3);
      m0_read_req = (op == 1); m0_write_req = (op >= 2);
      m0_addr = ADDR_W'($urandom); m0_size = SIZE_W'($urandom); m0_wr_data = {4{$urandom}};
      op = $urandom_range(3);
      m1_read_req = (op == 1); m1_write_req = (op >= 2);
      m1_addr = ADDR_W'($urandom); m1_size = SIZE_W'($urandom); m1_wr_data = {4{$urandom}};
      avl_ready = ($urandom_range(3) != 0);
      avl_read_valid = (m_pend > 0) && ($urandom_range(1) == 1);
      avl_read_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    idle_inputs(); avl_ready = 1;
    tick(); tick();
    drain("rand");

    // reset in the middle of a write burst
    m1_write_req = 1; m1_size = 7; m1_addr = 26'h777;
    tick(); tick();
    reset = 1; m0_read_req = 1; m0_size = 1; m0_addr = 26'h12;
    @(negedge clk);
    chk("rst_mid", {avl_write_req, avl_read_req, avl_burstbegin, m0_ready, m1_ready, err_orphan}, 6'b0);
    tick();
    reset = 0; m1_write_req = 0;
    @(negedge clk);
    chk("post_rst", {avl_read_req, avl_burstbegin, m0_ready, avl_write_req, err_orphan}, 5'b11100);
    tick();
    m0_read_req = 0;
    drain("post_rst");
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
